// File: rtl/l2_pkg.sv
// Shared types and helpers for the L2 way controller: FSM states, address-mux
// encodings and packed-age extraction.
package l2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVICT = 2'd1,
    FILL  = 2'd2
  } l2_state_t;

  localparam logic [1:0] ADDR_SEL_REQ    = 2'b00;
  localparam logic [1:0] ADDR_SEL_VICTIM = 2'b01;

  // Widest supported configuration is 16 ways x 4-bit ages.
  localparam int MAX_AGE_BITS = 64;
  localparam int AGE_W        = 4;

  // Age of way w from a packed age vector with aw bits per way.
  function automatic logic [AGE_W-1:0] age_of(input logic [MAX_AGE_BITS-1:0] ages,
                                              input int w, input int aw);
    logic [MAX_AGE_BITS-1:0] sh;
    sh = ages >> (w * aw);
    return sh[AGE_W-1:0] & AGE_W'((1 << aw) - 1);
  endfunction

endpackage

// File: rtl/l2_victim_select.sv
// Combinational victim choice: lowest-index invalid way, otherwise the
// lowest-index way carrying the LRU age (WAYS-1).
module l2_victim_select
  import l2_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int AW   = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]    valid_out,
  input  logic [WAYS*AW-1:0] lru_age,
  output logic [AW-1:0]      victim
);

  logic [AW-1:0] inv_idx;
  logic [AW-1:0] lru_idx;
  logic          any_inv;

  // Scanning downwards lets the lowest matching index win.
  always_comb begin
    inv_idx = '0;
    lru_idx = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_out[w]) begin
        inv_idx = AW'(w);
        any_inv = 1'b1;
      end
      if (age_of(MAX_AGE_BITS'(lru_age), w, AW) == AGE_W'(WAYS - 1))
        lru_idx = AW'(w);
    end
    victim = any_inv ? inv_idx : lru_idx;
  end

endmodule

// File: rtl/l2_way_control.sv
// WAYS-way write-back L2 control FSM: hit detection, true-LRU update strobes,
// registered victim, EWB write-back sequencing, fill and saturating counters.
module l2_way_control
  import l2_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int AW    = $clog2(WAYS),
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pmem_read,
  input  logic                pmem_write,
  input  logic                physical_resp,
  input  logic [WAYS-1:0]     valid_out,
  input  logic [WAYS-1:0]     dirty_out,
  input  logic [WAYS-1:0]     hit_vec,
  input  logic [WAYS*AW-1:0]  lru_age,
  input  logic                ewb_empty,
  input  logic                fill_ready,
  input  logic                clr_hits,
  input  logic                clr_miss,
  output logic                pmem_resp,
  output logic                physical_read,
  output logic                physical_write,
  output logic                load_ewb,
  output logic                l2_evict,
  output logic [WAYS-1:0]     data_write,
  output logic [WAYS-1:0]     tag_write,
  output logic [WAYS-1:0]     valid_write,
  output logic [WAYS-1:0]     dirty_write,
  output logic [WAYS-1:0]     lru_inc,
  output logic [WAYS-1:0]     lru_clr,
  output logic                dirty_write_val,
  output logic                wdatamux_sel,
  output logic [AW-1:0]       way_sel,
  output logic [1:0]          addr_sel,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  l2_state_t     state_q, state_d;
  logic [AW-1:0] victim_q, victim_c, hit_idx;
  logic          ewb_loaded_q;
  logic          latch_victim, hit_inc, miss_inc;
  logic          req, hit, all_valid;
  logic [WAYS-1:0] vic_oh, younger_hit, younger_vic;

  assign req       = pmem_read | pmem_write;
  assign hit       = |hit_vec;
  assign all_valid = &valid_out;
  assign vic_oh    = WAYS'(1) << victim_q;

  l2_victim_select #(.WAYS(WAYS), .AW(AW)) u_victim (
    .valid_out (valid_out),
    .lru_age   (lru_age),
    .victim    (victim_c)
  );

  always_comb begin
    hit_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_idx = AW'(w);
  end

  // Ways younger than the way being promoted to MRU age by one.
  always_comb begin
    younger_hit = '0;
    younger_vic = '0;
    for (int w = 0; w < WAYS; w++) begin
      younger_hit[w] = age_of(MAX_AGE_BITS'(lru_age), w, AW) <
                       age_of(MAX_AGE_BITS'(lru_age), int'(hit_idx), AW);
      younger_vic[w] = age_of(MAX_AGE_BITS'(lru_age), w, AW) <
                       age_of(MAX_AGE_BITS'(lru_age), int'(victim_q), AW);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      victim_q     <= '0;
      ewb_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (latch_victim) victim_q <= victim_c;
      ewb_loaded_q <= (state_q == EVICT) ? (ewb_loaded_q | load_ewb) : 1'b0;
    end
  end

  // Everything is gated by rst so strobes drop in the same cycle it rises.
  always_comb begin
    state_d         = state_q;
    latch_victim    = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    pmem_resp       = 1'b0;
    physical_read   = 1'b0;
    physical_write  = 1'b0;
    load_ewb        = 1'b0;
    l2_evict        = 1'b0;
    data_write      = '0;
    tag_write       = '0;
    valid_write     = '0;
    dirty_write     = '0;
    lru_inc         = '0;
    lru_clr         = '0;
    dirty_write_val = 1'b0;
    wdatamux_sel    = 1'b0;
    way_sel         = '0;
    addr_sel        = ADDR_SEL_REQ;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (req && hit) begin
            pmem_resp = 1'b1;
            lru_clr   = hit_vec;
            lru_inc   = younger_hit;
            hit_inc   = pmem_read;
            if (pmem_write) begin
              data_write      = hit_vec;
              dirty_write     = hit_vec;
              dirty_write_val = 1'b1;
            end
          end else if (req) begin
            latch_victim = 1'b1;
            state_d      = (all_valid && dirty_out[victim_c]) ? EVICT : FILL;
          end
        end
        EVICT: begin
          way_sel        = victim_q;
          addr_sel       = ADDR_SEL_VICTIM;
          l2_evict       = 1'b1;
          physical_write = 1'b1;
          load_ewb       = ewb_empty && !ewb_loaded_q;
          if (physical_resp) begin
            dirty_write = vic_oh;
            state_d     = FILL;
          end
        end
        FILL: begin
          if (fill_ready) begin
            physical_read = 1'b1;
            wdatamux_sel  = 1'b1;
            way_sel       = victim_q;
            if (physical_resp) begin
              data_write  = vic_oh;
              tag_write   = vic_oh;
              valid_write = vic_oh;
              lru_clr     = vic_oh;
              lru_inc     = younger_vic;
              miss_inc    = 1'b1;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (clr_hits)                      hit_cnt <= '0;
      else if (hit_inc && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      if (clr_miss)                        miss_cnt <= '0;
      else if (miss_inc && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_way_control.sv
// Directed bench for l2_way_control: a 4-way/4-bit-counter instance for the
// FSM and counters, and an 8-way instance for victim choice.
module tb_l2_way_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-way instance
  logic pmem_read, pmem_write, physical_resp, ewb_empty, fill_ready, clr_hits, clr_miss;
  logic [3:0] valid_out, dirty_out, hit_vec;
  logic [7:0] lru_age;
  logic pmem_resp, physical_read, physical_write, load_ewb, l2_evict, dirty_write_val, wdatamux_sel;
  logic [3:0] data_write, tag_write, valid_write, dirty_write, lru_inc, lru_clr;
  logic [1:0] way_sel, addr_sel;
  logic [3:0] hit_cnt, miss_cnt;

  l2_way_control #(.WAYS(4), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .physical_resp(physical_resp), .valid_out(valid_out), .dirty_out(dirty_out),
    .hit_vec(hit_vec), .lru_age(lru_age), .ewb_empty(ewb_empty), .fill_ready(fill_ready),
    .clr_hits(clr_hits), .clr_miss(clr_miss), .pmem_resp(pmem_resp),
    .physical_read(physical_read), .physical_write(physical_write), .load_ewb(load_ewb),
    .l2_evict(l2_evict), .data_write(data_write), .tag_write(tag_write),
    .valid_write(valid_write), .dirty_write(dirty_write), .lru_inc(lru_inc),
    .lru_clr(lru_clr), .dirty_write_val(dirty_write_val), .wdatamux_sel(wdatamux_sel),
    .way_sel(way_sel), .addr_sel(addr_sel), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // 8-way instance
  logic pmem_read8, physical_resp8;
  logic [7:0] valid8, dirty8, hit8;
  logic [23:0] age8;
  logic pmem_resp8, physical_read8, physical_write8, load_ewb8, l2_evict8, dwv8, wdm8;
  logic [7:0] data_write8, tag_write8, valid_write8, dirty_write8, lru_inc8, lru_clr8;
  logic [2:0] way_sel8;
  logic [1:0] addr_sel8;
  logic [15:0] hit_cnt8, miss_cnt8;

  l2_way_control #(.WAYS(8)) u_dut8 (
    .clk(clk), .rst(rst), .pmem_read(pmem_read8), .pmem_write(1'b0),
    .physical_resp(physical_resp8), .valid_out(valid8), .dirty_out(dirty8),
    .hit_vec(hit8), .lru_age(age8), .ewb_empty(1'b1), .fill_ready(1'b1),
    .clr_hits(1'b0), .clr_miss(1'b0), .pmem_resp(pmem_resp8),
    .physical_read(physical_read8), .physical_write(physical_write8), .load_ewb(load_ewb8),
    .l2_evict(l2_evict8), .data_write(data_write8), .tag_write(tag_write8),
    .valid_write(valid_write8), .dirty_write(dirty_write8), .lru_inc(lru_inc8),
    .lru_clr(lru_clr8), .dirty_write_val(dwv8), .wdatamux_sel(wdm8),
    .way_sel(way_sel8), .addr_sel(addr_sel8), .hit_cnt(hit_cnt8), .miss_cnt(miss_cnt8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pmem_read = 0; pmem_write = 0; physical_resp = 0; ewb_empty = 1; fill_ready = 1;
    clr_hits = 0; clr_miss = 0; valid_out = 4'b1111; dirty_out = 0; hit_vec = 4'b0100;
    lru_age = 8'he4;  // way0..3 ages 0,1,2,3
    pmem_read8 = 0; physical_resp8 = 0; valid8 = '1; dirty8 = 0; hit8 = 0; age8 = 0;

    // Reset: a hitting request must not produce strobes while rst is high
    pmem_read = 1;
    #1;
    chk("rst_pmem_resp", pmem_resp, 0);
    chk("rst_lru_clr", lru_clr, 0);
    tick();
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_addr_sel", addr_sel, 0);
    pmem_read = 0;
    rst = 0;
    tick();

    // Read hit on way2
    pmem_read = 1; hit_vec = 4'b0100;
    #1;
    chk("hit_resp", pmem_resp, 1);
    chk("hit_lru_clr", lru_clr, 4'b0100);
    chk("hit_lru_inc", lru_inc, 4'b0011);
    chk("hit_no_dwrite", data_write, 0);
    tick();
    chk("hit_cnt_1", hit_cnt, 1);
    pmem_read = 0;

    // Write hit on way1
    pmem_write = 1; hit_vec = 4'b0010;
    #1;
    chk("whit_dwrite", data_write, 4'b0010);
    chk("whit_dirty", {dirty_write, 3'b0, dirty_write_val}, {4'b0010, 4'b0001});
    chk("whit_lru_inc", lru_inc, 4'b0001);
    tick();
    chk("whit_no_cnt", hit_cnt, 1);
    pmem_write = 0;

    // Dirty miss: all valid, way3 dirty LRU
    pmem_read = 1; hit_vec = 0; dirty_out = 4'b1000;
    #1;
    chk("dm_idle_resp", pmem_resp, 0);
    tick();
    chk("ev_load_ewb", load_ewb, 1);
    chk("ev_way_sel", way_sel, 3);
    chk("ev_addr_sel", addr_sel, 2'b01);
    chk("ev_pw_evict", {physical_write, l2_evict}, 2'b11);
    tick();
    chk("ev_load_once", load_ewb, 0);
    chk("ev_pw_held", physical_write, 1);
    physical_resp = 1;
    #1;
    chk("ev_dirty_clr", {dirty_write, 3'b0, dirty_write_val}, {4'b1000, 4'b0000});
    tick();
    physical_resp = 0;
    #1;
    chk("fill_pread", physical_read, 1);
    chk("fill_way_sel", way_sel, 3);
    chk("fill_no_evict", {l2_evict, physical_write, addr_sel}, 0);
    physical_resp = 1;
    #1;
    chk("fill_dwrite", data_write, 4'b1000);
    chk("fill_tv_write", {tag_write, valid_write}, {4'b1000, 4'b1000});
    chk("fill_lru", {lru_clr, lru_inc}, {4'b1000, 4'b0111});
    tick();
    physical_resp = 0;
    chk("miss_cnt_1", miss_cnt, 1);
    hit_vec = 4'b1000;
    #1;
    chk("post_fill_hit", pmem_resp, 1);
    tick();
    chk("hit_cnt_2", hit_cnt, 2);
    pmem_read = 0;

    // Clean miss: way2 invalid -> straight to FILL; ages change mid-FILL
    valid_out = 4'b1011; dirty_out = 4'b1111; hit_vec = 0; pmem_read = 1;
    tick();
    chk("cm_no_evict", {l2_evict, physical_write}, 0);
    chk("cm_way_sel", way_sel, 2);
    lru_age = 8'h1b; valid_out = 4'b1111;  // ages now 3,2,1,0
    physical_resp = 1; pmem_read = 0;
    #1;
    chk("cm_dwrite_stable", data_write, 4'b0100);
    chk("cm_lru", {lru_clr, lru_inc}, {4'b0100, 4'b1000});
    tick();
    physical_resp = 0;
    chk("miss_cnt_2", miss_cnt, 2);

    // EWB busy for 3 cycles, then fill path stalled
    lru_age = 8'he4; dirty_out = 4'b1000; ewb_empty = 0; pmem_read = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ewb_busy", load_ewb, 0);
      tick();
    end
    ewb_empty = 1;
    #1;
    chk("ewb_pulse", load_ewb, 1);
    tick();
    chk("ewb_pulse_once", load_ewb, 0);
    physical_resp = 1;
    tick();
    physical_resp = 0; fill_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("fill_stall_pread", physical_read, 0);
      tick();
    end
    fill_ready = 1; physical_resp = 1; pmem_read = 0;
    #1;
    chk("fill_resume", physical_read, 1);
    tick();
    physical_resp = 0;
    chk("miss_cnt_3", miss_cnt, 3);

    // Counter clear priority and saturation
    hit_vec = 4'b0001; pmem_read = 1; clr_hits = 1;
    tick();
    clr_hits = 0;
    chk("clr_hits", hit_cnt, 0);
    chk("clr_hits_only", miss_cnt, 3);
    repeat (20) tick();
    chk("hit_sat", hit_cnt, 15);
    pmem_read = 0; clr_miss = 1;
    tick();
    clr_miss = 0;
    chk("clr_miss", {hit_cnt, miss_cnt}, {4'd15, 4'd0});

    // Reset mid-FILL
    valid_out = 4'b1011; hit_vec = 0; pmem_read = 1;
    tick();
    chk("pre_rst_pread", physical_read, 1);
    rst = 1;
    #1;
    chk("rst_fill_strobes", {physical_read, wdatamux_sel, way_sel, pmem_resp, data_write}, 0);
    tick();
    chk("rst_fill_cnt", hit_cnt, 0);
    pmem_read = 0;
    rst = 0;
    tick();
    chk("rst_idle", physical_read, 0);

    // 8-way: lowest-index way at age 7 is the victim
    for (int w = 0; w < 8; w++) age8[w*3 +: 3] = 3'(w);
    age8[3*3 +: 3] = 3'd6;
    age8[5*3 +: 3] = 3'd7;
    age8[6*3 +: 3] = 3'd7;
    pmem_read8 = 1;
    tick();
    chk("w8_victim", way_sel8, 5);
    chk("w8_clean_fill", {physical_read8, physical_write8}, 2'b10);
    pmem_read8 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/l2_way_control.md
# l2_way_control

Parametrised control FSM for the L2 cache: a WAYS-way set-associative write-back controller between the L1/arbiter side (pmem_*) and physical memory (physical_*). It detects hits, keeps per-set age-based true-LRU, selects and latches an eviction victim, sequences write-back through the eviction write buffer (EWB), fills from memory, and keeps saturating hit/miss counters. It replaces the fixed 4-way control, which had no registered victim, no fill-time LRU update and no counter saturation.

## Interface
- WAYS, 4, associativity; power of two, 2..16
- AW, $clog2(WAYS), age and way-index width (derived)
- CNT_W, 16, hit/miss counter width
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pmem_read, pmem_write  in  1  request from upper level; held until pmem_resp
- physical_resp  in  1  memory completion pulse
- valid_out, dirty_out, hit_vec  in  WAYS  per-way status of the indexed set (hit_vec is one-hot or zero)
- lru_age  in  WAYS*AW  packed ages; way w occupies [w*AW +: AW]; 0 = MRU, WAYS-1 = LRU
- ewb_empty, fill_ready  in  1  EWB can accept a line / fill data path is ready
- clr_hits, clr_miss  in  1  synchronous counter clears
- pmem_resp, physical_read, physical_write, load_ewb, l2_evict  out  1
- data_write, tag_write, valid_write, dirty_write, lru_inc, lru_clr  out  WAYS  per-way strobes
- dirty_write_val, wdatamux_sel  out  1
- way_sel  out  AW  data/tag mux select for write-back and fill
- addr_sel  out  2  00 = request address, 01 = victim tag address
- hit_cnt, miss_cnt  out  CNT_W

## Operation
- States: IDLE, EVICT, FILL. Reset → IDLE; victim_q = 0; counters = 0; all strobes 0; addr_sel = 00.
- IDLE, request and hit:
  - pmem_resp = 1.
  - lru_clr[h] = 1; lru_inc[w] = 1 for every w with age[w] < age[h].
  - On write: data_write[h] = dirty_write[h] = 1 and dirty_write_val = 1.
- IDLE, request and no hit:
  - Victim = lowest-index invalid way; if all ways are valid, the lowest-index way with age == WAYS-1.
  - Latch the victim into victim_q.
  - Next state is EVICT if all ways are valid and the victim is dirty; otherwise FILL.
- EVICT:
  - way_sel = victim_q; addr_sel = 01; l2_evict = 1; physical_write = 1.
  - load_ewb pulses for exactly one cycle, on the first EVICT cycle with ewb_empty = 1.
  - On physical_resp: dirty_write[victim_q] = 1 with dirty_write_val = 0; next state FILL.
- FILL:
  - While fill_ready = 1: physical_read = 1, wdatamux_sel = 1, way_sel = victim_q.
  - On physical_resp with fill_ready = 1:
    - data_write, tag_write and valid_write of victim_q = 1.
    - lru_clr[victim_q] = 1; lru_inc on all ways with age < age[victim_q].
    - miss_cnt increments; next state IDLE, where the request now hits.
- hit_cnt increments once per pmem_resp cycle for a read request.
- Counters saturate at 2^CNT_W-1. Clear has priority over increment; each clear affects only its own counter.
- physical_resp in IDLE is ignored. Requests that arrive outside IDLE are not sampled.

## Timing
- Hit: pmem_resp is combinational, in the same cycle as the request.
- Clean miss: FILL is entered on the cycle after detection. Dirty miss: EVICT is entered on the cycle after detection. Then pmem_resp follows 1 cycle after the fill physical_resp.
- victim_q is stable for the whole EVICT/FILL episode, even if lru_age or valid_out change.
- physical_read and physical_write are held until physical_resp.
- rst asserted mid-EVICT or mid-FILL: the FSM returns to IDLE immediately and every strobe deasserts in the same cycle.

## Structure
- Package l2_pkg holds:
  - the state enum l2_state_t;
  - addr_sel encodings;
  - the function age_of(lru_age, w).
- One sub-module, l2_victim_select: combinational, WAYS-parametrised, takes valid_out and lru_age, outputs the victim index. The FSM, victim register and counters stay in the top module.

## Test plan
- WAYS=4: read with hit_vec=0100 and ages {0,1,2,3} (way0..3) → pmem_resp same cycle; lru_clr=0100; lru_inc=0011; hit_cnt 0→1.
- All ways valid, way3 dirty with age 3, no hit → next cycle EVICT, load_ewb pulses 1 cycle, way_sel=3, addr_sel=01. On physical_resp: FILL, then data_write=1000, miss_cnt=1.
- valid_out=1011 → victim way2, direct to FILL with no EVICT. Ages changed during FILL → data_write still 0100.
- EVICT with ewb_empty=0 for 3 cycles → load_ewb=0 during those cycles; single pulse on the first cycle ewb_empty=1. Same stimulus with fill_ready=0 in FILL → physical_read stays low.
- CNT_W=4: 20 read hits → hit_cnt stays at 15. clr_hits together with a hit → hit_cnt=0 next cycle.
- rst asserted mid-FILL → IDLE, all strobes 0 at once. WAYS=8: lowest-index age-7 way is chosen as victim.
